trsq8_irq_ctrl: RTL and testbench

//  Interrupt controller driving the TRSQ8 core's irq input. Collects NUM_SRC request lines,

---
 rtl/trsq8_irq_pkg.sv | 23 ++
 rtl/trsq8_irq_ctrl_if.sv | 30 +++
 rtl/trsq8_irq_prio_enc.sv | 23 ++
 rtl/trsq8_irq_ctrl.sv | 149 ++++++++++++++
 tb/tb_trsq8_irq_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/trsq8_irq_pkg.sv
// Shared types and helpers for the TRSQ8 interrupt controller.
// Optional edge-triggered request capture is selected with TRSQ8_IRQ_EDGE_EN.
package trsq8_irq_pkg;

    localparam int NUM_SRC_MAX = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Ceiling log2, used at elaboration to size the vector.
    function automatic int clog2(input int n);
        int r;
        r = 32'sd0;
        while ((32'sd1 << r) < n) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/trsq8_irq_ctrl_if.sv
// Bus between request sources / TRSQ8 core (master) and the interrupt controller (slave).
interface trsq8_irq_ctrl_if #(
    parameter int NUM_SRC = 8
);
    import trsq8_irq_pkg::*;

    localparam int VEC_W = clog2(NUM_SRC);

    logic [NUM_SRC-1:0] src;
    logic               ien_we;
    logic [NUM_SRC-1:0] ien_wdata;
    logic [NUM_SRC-1:0] ien;
    logic [NUM_SRC-1:0] pending;
    logic               irq;
    logic [VEC_W-1:0]   irq_vec;
    logic               irq_ack;
    logic               irq_eoi;
    logic               busy;

    modport master (
        output src, ien_we, ien_wdata, irq_ack, irq_eoi,
        input  ien, pending, irq, irq_vec, busy
    );

    modport slave (
        input  src, ien_we, ien_wdata, irq_ack, irq_eoi,
        output ien, pending, irq, irq_vec, busy
    );

endinterface

// File: rtl/trsq8_irq_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module trsq8_irq_prio_enc
    import trsq8_irq_pkg::*;
#(
    parameter  int NUM_SRC = 8,
    localparam int VEC_W   = clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [VEC_W-1:0]   vec,
    output logic               any
);

    // Scan from the top down so the lowest active index is the last one written.
    always_comb begin
        vec = {VEC_W{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            vec = req[i] ? VEC_W'(i) : vec;
        end
    end

    assign any = |req;

endmodule

// File: rtl/trsq8_irq_ctrl.sv
// TRSQ8 interrupt controller: pending/enable registers, priority select, ack/eoi handshake.
// Define TRSQ8_IRQ_EDGE_EN for sticky rising-edge capture instead of level-following pending.
module trsq8_irq_ctrl
    import trsq8_irq_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic           clk,
    input  logic           reset,
    trsq8_irq_ctrl_if.slave bus
);

    localparam int VEC_W = clog2(NUM_SRC);

    irq_state_t         state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] ien_q, ien_d;
    logic               irq_q, irq_d;
    logic [VEC_W-1:0]   irq_vec_q, irq_vec_d;
    logic               busy_q, busy_d;

    logic [NUM_SRC-1:0] req_s;
    logic [VEC_W-1:0]   enc_vec_s;
    logic               enc_any_s;

    assign req_s = pending_q & ien_q;

    trsq8_irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .req (req_s),
        .vec (enc_vec_s),
        .any (enc_any_s)
    );

    // Enable register write-through.
    always_comb begin
        ien_d = ien_q;
        if (bus.ien_we) begin
            ien_d = bus.ien_wdata;
        end else begin
            ien_d = ien_q;
        end
    end

`ifdef TRSQ8_IRQ_EDGE_EN
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pend_clr_s;

    // Ack retires the frozen vector; a same-cycle rising edge still lands because set wins.
    always_comb begin
        pend_clr_s = {NUM_SRC{1'b0}};
        if ((state_q == REQ) && bus.irq_ack) begin
            pend_clr_s = {{(NUM_SRC-1){1'b0}}, 1'b1} << irq_vec_q;
        end else begin
            pend_clr_s = {NUM_SRC{1'b0}};
        end
        pending_d = (pending_q & ~pend_clr_s) | (bus.src & ~src_q);
    end

    // Previous-cycle copy of the request lines for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q <= {NUM_SRC{1'b0}};
        end else begin
            src_q <= bus.src;
        end
    end
`else
    // Level mode: pending simply mirrors the request lines one cycle late.
    always_comb begin
        pending_d = bus.src;
    end
`endif

    // Handshake FSM: IDLE raises irq, REQ tracks priority until ack, SERVICE waits for eoi.
    always_comb begin
        state_d   = state_q;
        irq_d     = irq_q;
        irq_vec_d = irq_vec_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (enc_any_s) begin
                    state_d   = REQ;
                    irq_d     = 1'b1;
                    irq_vec_d = enc_vec_s;
                end else begin
                    irq_d     = 1'b0;
                end
            end
            REQ: begin
                if (bus.irq_ack) begin
                    state_d = SERVICE;
                    irq_d   = 1'b0;
                    busy_d  = 1'b1;
                end else if (!enc_any_s) begin
                    state_d = IDLE;
                    irq_d   = 1'b0;
                end else begin
                    irq_d     = 1'b1;
                    irq_vec_d = enc_vec_s;
                end
            end
            SERVICE: begin
                irq_d = 1'b0;
                if (bus.irq_eoi) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                irq_d     = 1'b0;
                irq_vec_d = {VEC_W{1'b0}};
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= {NUM_SRC{1'b0}};
            ien_q     <= {NUM_SRC{1'b0}};
            irq_q     <= 1'b0;
            irq_vec_q <= {VEC_W{1'b0}};
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ien_q     <= ien_d;
            irq_q     <= irq_d;
            irq_vec_q <= irq_vec_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.ien     = ien_q;
    assign bus.pending = pending_q;
    assign bus.irq     = irq_q;
    assign bus.irq_vec = irq_vec_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_trsq8_irq_ctrl.sv
// Self-checking bench for trsq8_irq_ctrl: directed scenarios plus randomized traffic vs a model.
module tb_trsq8_irq_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    trsq8_irq_ctrl_if #(.NUM_SRC(8)) bus ();

    trsq8_irq_ctrl #(.NUM_SRC(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: "requesting" is irq high, "in service" is busy high.
    logic [7:0] m_pend, m_ien, m_src_prev;
    logic       m_irq, m_busy;
    logic [2:0] m_vec;

    function automatic logic [2:0] lowest(input logic [7:0] r);
        for (int i = 0; i < 8; i++) begin
            if (r[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [7:0] req, clr, n_pend, n_ien;
        logic       n_irq, n_busy;
        logic [2:0] n_vec;
        req    = m_pend & m_ien;
        clr    = 8'h00;
        n_irq  = m_irq;
        n_busy = m_busy;
        n_vec  = m_vec;
        n_ien  = bus.ien_we ? bus.ien_wdata : m_ien;
        if (m_busy) begin
            if (bus.irq_eoi) n_busy = 1'b0;
        end else if (m_irq) begin
            if (bus.irq_ack) begin
                n_busy = 1'b1;
                n_irq  = 1'b0;
                clr    = 8'h01 << m_vec;
            end else if (req == 8'h00) begin
                n_irq = 1'b0;
            end else begin
                n_vec = lowest(req);
            end
        end else if (req != 8'h00) begin
            n_irq = 1'b1;
            n_vec = lowest(req);
        end
`ifdef TRSQ8_IRQ_EDGE_EN
        n_pend = (m_pend & ~clr) | (bus.src & ~m_src_prev);
`else
        n_pend = bus.src;
`endif
        if (reset) begin
            m_pend = 8'h00; m_ien = 8'h00; m_irq = 1'b0; m_busy = 1'b0;
            m_vec = 3'd0; m_src_prev = 8'h00;
        end else begin
            m_pend = n_pend; m_ien = n_ien; m_irq = n_irq; m_busy = n_busy;
            m_vec = n_vec; m_src_prev = bus.src;
        end
    endtask

    // One clock: advance the model on the edge, compare all outputs just after it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("irq",     32'(bus.irq),     32'(m_irq));
        chk("irq_vec", 32'(bus.irq_vec), 32'(m_vec));
        chk("busy",    32'(bus.busy),    32'(m_busy));
        chk("pending", 32'(bus.pending), 32'(m_pend));
        chk("ien",     32'(bus.ien),     32'(m_ien));
    endtask

    task automatic idle_inputs();
        bus.src = 8'h00; bus.ien_we = 1'b0; bus.ien_wdata = 8'h00;
        bus.irq_ack = 1'b0; bus.irq_eoi = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic write_ien(input logic [7:0] v);
        bus.ien_we = 1'b1; bus.ien_wdata = v;
        step();
        bus.ien_we = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        bus.irq_eoi = 1'b1; step(); bus.irq_eoi = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        m_pend = 8'h00; m_ien = 8'h00; m_src_prev = 8'h00;
        m_irq = 1'b0; m_busy = 1'b0; m_vec = 3'd0;
        idle_inputs();

        // 1: reset with all sources high
        reset = 1'b1; bus.src = 8'hFF;
        step(); step();
        chk("t1_irq", 32'(bus.irq), 32'd0);
        chk("t1_pending", 32'(bus.pending), 32'd0);
        chk("t1_ien", 32'(bus.ien), 32'd0);
        chk("t1_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        step(); step();
        chk("t1_no_irq_masked", 32'(bus.irq), 32'd0);

        // 2: single request, ack, eoi
        do_reset();
        write_ien(8'h01);
        bus.src = 8'h01;
        step();
        chk("t2_lat1", 32'(bus.irq), 32'd0);
        step();
        chk("t2_irq", 32'(bus.irq), 32'd1);
        chk("t2_vec", 32'(bus.irq_vec), 32'd0);
        pulse_ack();
        chk("t2_ack_irq", 32'(bus.irq), 32'd0);
        chk("t2_ack_busy", 32'(bus.busy), 32'd1);
        bus.src = 8'h00;
        step();
        pulse_eoi();
        chk("t2_eoi_busy", 32'(bus.busy), 32'd0);
        step();
        chk("t2_after_irq", 32'(bus.irq), 32'd0);

        // 3: priority and preemption
        do_reset();
        write_ien(8'hFF);
        bus.src = 8'h08;
        step(); step();
        chk("t3_vec3", 32'(bus.irq_vec), 32'd3);
        bus.src = 8'h0A;
        step(); step();
        chk("t3_vec1", 32'(bus.irq_vec), 32'd1);
        chk("t3_irq", 32'(bus.irq), 32'd1);
        pulse_ack();
        chk("t3_frozen", 32'(bus.irq_vec), 32'd1);
        chk("t3_busy", 32'(bus.busy), 32'd1);

        // 4: withdraw by masking, then a stray ack
        do_reset();
        write_ien(8'h04);
        bus.src = 8'h04;
        step(); step();
        chk("t4_irq", 32'(bus.irq), 32'd1);
        chk("t4_vec", 32'(bus.irq_vec), 32'd2);
        write_ien(8'h00);
        step();
        chk("t4_drop", 32'(bus.irq), 32'd0);
        pulse_ack();
        chk("t4_ack_ignored", 32'(bus.busy), 32'd0);
        step();
        chk("t4_still_idle", 32'(bus.irq), 32'd0);

        // 5: source held through eoi
        do_reset();
        write_ien(8'h20);
        bus.src = 8'h20;
        step(); step();
        chk("t5_vec", 32'(bus.irq_vec), 32'd5);
        pulse_ack();
        step(); step();
        pulse_eoi();
        chk("t5_eoi_irq", 32'(bus.irq), 32'd0);
        step();
`ifdef TRSQ8_IRQ_EDGE_EN
        chk("t5_no_reraise", 32'(bus.irq), 32'd0);
`else
        chk("t5_reraise", 32'(bus.irq), 32'd1);
        chk("t5_reraise_vec", 32'(bus.irq_vec), 32'd5);
`endif

`ifdef TRSQ8_IRQ_EDGE_EN
        // 6: new edge coincides with the ack of the same vector
        do_reset();
        write_ien(8'h01);
        bus.src = 8'h01;
        step(); step();
        chk("t6_irq", 32'(bus.irq), 32'd1);
        bus.src = 8'h00;
        step();
        bus.src = 8'h01;
        pulse_ack();
        chk("t6_pend0", 32'(bus.pending[0]), 32'd1);
        chk("t6_busy", 32'(bus.busy), 32'd1);
        pulse_eoi();
        step();
        chk("t6_reraise", 32'(bus.irq), 32'd1);
        chk("t6_vec", 32'(bus.irq_vec), 32'd0);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) bus.src = 8'($urandom);
            bus.ien_we    = ($urandom_range(0, 11) == 0);
            bus.ien_wdata = 8'($urandom);
            bus.irq_ack   = ($urandom_range(0, 3) == 0);
            bus.irq_eoi   = ($urandom_range(0, 3) == 0);
            step();
        end
        reset = 1'b0;
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
